// File: rtl/fp32_mul_result_stage.sv
// Result stage for the fp32 multiplier: a valid/ready FIFO that also classifies products and keeps sticky flags and a counter.
// Optional macro FP32_RESULT_NAN_CANON_EN: when defined, every accepted NaN is stored as canonical 32'h7FC00000.
module fp32_mul_result_stage #(
  parameter int DEPTH     = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_result,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_result,
  output logic [3:0]               out_class,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     flag_nan,
  output logic                     flag_inf,
  output logic                     flag_zero,
  input  logic                     flag_clr,
  output logic [CNT_WIDTH-1:0]     prod_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]        level_q, level_d;
  logic                 flag_nan_q, flag_nan_d;
  logic                 flag_inf_q, flag_inf_d;
  logic                 flag_zero_q, flag_zero_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;

  logic [31:0] data_mem_q  [DEPTH];
  logic [3:0]  class_mem_q [DEPTH];

  logic        push, pop;
  logic [7:0]  in_exp;
  logic        in_mant_nz;
  logic [3:0]  in_class;
  logic [31:0] in_store;

  assign in_ready  = (level_q != FULL_LEVEL);
  assign out_valid = (level_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Class bits are {nan, inf, zero, normal}; denormals arrive already flushed, so exp==0 is zero.
  assign in_exp     = in_result[30:23];
  assign in_mant_nz = |in_result[22:0];
  assign in_class   = {(in_exp == 8'hFF) &  in_mant_nz,
                       (in_exp == 8'hFF) & ~in_mant_nz,
                       (in_exp == 8'h00),
                       (in_exp != 8'h00) & (in_exp != 8'hFF)};

`ifdef FP32_RESULT_NAN_CANON_EN
  assign in_store = in_class[3] ? 32'h7FC0_0000 : in_result;
`else
  assign in_store = in_result;
`endif

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    level_d  = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    // A setting push beats a coincident clear so no event is lost.
    flag_nan_d  = (flag_nan_q  & ~flag_clr) | (push & in_class[3]);
    flag_inf_d  = (flag_inf_q  & ~flag_clr) | (push & in_class[2]);
    flag_zero_d = (flag_zero_q & ~flag_clr) | (push & in_class[1]);
    count_d     = (push && (count_q != '1)) ? count_q + CNT_WIDTH'(1) : count_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      flag_nan_q  <= 1'b0;
      flag_inf_q  <= 1'b0;
      flag_zero_q <= 1'b0;
      count_q     <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      flag_nan_q  <= flag_nan_d;
      flag_inf_q  <= flag_inf_d;
      flag_zero_q <= flag_zero_d;
      count_q     <= count_d;
    end
  end

  // Storage carries no reset; validity is tracked entirely by level_q.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (push && (wr_ptr_q == PW'(gi))) begin
          data_mem_q[gi]  <= in_store;
          class_mem_q[gi] <= in_class;
        end
      end
    end
  endgenerate

  assign out_result = out_valid ? data_mem_q[rd_ptr_q]  : 32'h0;
  assign out_class  = out_valid ? class_mem_q[rd_ptr_q] : 4'h0;
  assign level      = level_q;
  assign flag_nan   = flag_nan_q;
  assign flag_inf   = flag_inf_q;
  assign flag_zero  = flag_zero_q;
  assign prod_count = count_q;

endmodule

// File: tb/tb_fp32_mul_result_stage.sv
// Self-checking bench for fp32_mul_result_stage: vector table, directed corner sequences and randomized traffic vs a queue model.
module tb_fp32_mul_result_stage;
  localparam int DEPTH = 4;
  localparam int CW    = 4;
  localparam int LW    = $clog2(DEPTH) + 1;
`ifdef FP32_RESULT_NAN_CANON_EN
  localparam logic [31:0] NAN_EXP = 32'h7FC0_0000;
`else
  localparam logic [31:0] NAN_EXP = 32'hFFC0_0000;
`endif

  logic          clk = 1'b0;
  logic          rst, in_valid, in_ready, out_valid, out_ready, flag_clr;
  logic [31:0]   in_result, out_result;
  logic [3:0]    out_class;
  logic [LW-1:0] level;
  logic          flag_nan, flag_inf, flag_zero;
  logic [CW-1:0] prod_count;

  always #5 clk = ~clk;

  fp32_mul_result_stage #(.DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_class(out_class),
    .level(level), .flag_nan(flag_nan), .flag_inf(flag_inf), .flag_zero(flag_zero),
    .flag_clr(flag_clr), .prod_count(prod_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: FIFO contents as queues, flags and counter as plain values.
  logic [31:0] mq_data[$];
  logic [3:0]  mq_cls[$];
  bit          m_nan, m_inf, m_zero;
  int          m_cnt;

  typedef struct {
    bit          iv;
    bit          ordy;
    logic [31:0] din;
    int          e_level;
    bit          e_in_ready;
    bit          e_out_valid;
    logic [31:0] e_result;
    logic [3:0]  e_class;
    logic [2:0]  e_flags;   // {nan, inf, zero}
  } vec_t;

  vec_t tbl[8];

  function automatic logic [3:0] ref_class(logic [31:0] x);
    int e = int'(x[30:23]);
    int m = int'(x[22:0]);
    if (e == 255 && m != 0) return 4'b1000;
    if (e == 255)           return 4'b0100;
    if (e == 0)             return 4'b0010;
    return 4'b0001;
  endfunction

  function automatic logic [31:0] ref_store(logic [31:0] x);
`ifdef FP32_RESULT_NAN_CANON_EN
    if (ref_class(x) == 4'b1000) return 32'h7FC0_0000;
`endif
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    check("level",      32'(level),      32'(mq_data.size()));
    check("in_ready",   32'(in_ready),   32'(mq_data.size() < DEPTH));
    check("out_valid",  32'(out_valid),  32'(mq_data.size() > 0));
    check("out_result", out_result,      mq_data.size() > 0 ? mq_data[0] : 32'h0);
    check("out_class",  32'(out_class),  32'(mq_data.size() > 0 ? mq_cls[0] : 4'h0));
    check("flags",      32'({flag_nan, flag_inf, flag_zero}), 32'({m_nan, m_inf, m_zero}));
    check("prod_count", 32'(prod_count), 32'(m_cnt));
  endtask

  // One clock: drive inputs, advance the model, sample 1ns after the edge and compare.
  task automatic cycle(input bit iv, input bit ordy, input bit clr, input logic [31:0] din, input bit r);
    bit do_push, do_pop;
    logic [31:0] popped;
    rst = r; in_valid = iv; out_ready = ordy; flag_clr = clr; in_result = din;
    do_push = !r && iv && (mq_data.size() < DEPTH);
    do_pop  = !r && ordy && (mq_data.size() > 0);
    popped  = do_pop ? mq_data[0] : 32'h0;
    @(posedge clk);
    #1;
    if (r) begin
      mq_data.delete(); mq_cls.delete();
      m_nan = 0; m_inf = 0; m_zero = 0; m_cnt = 0;
    end else begin
      if (do_pop) begin
        void'(mq_data.pop_front()); void'(mq_cls.pop_front());
      end
      if (clr) begin m_nan = 0; m_inf = 0; m_zero = 0; end
      if (do_push) begin
        mq_data.push_back(ref_store(din));
        mq_cls.push_back(ref_class(din));
        if (ref_class(din) == 4'b1000) m_nan = 1;
        if (ref_class(din) == 4'b0100) m_inf = 1;
        if (ref_class(din) == 4'b0010) m_zero = 1;
        if (m_cnt < (1 << CW) - 1) m_cnt++;
      end
    end
    $display("t=%0t rst=%0b push=%0b(%h) pop=%0b(%h) level=%0d", $time, r, do_push, din, do_pop, popped, level);
    check_model();
  endtask

  function automatic logic [31:0] rand_fp();
    logic [31:0] x = $urandom;
    case ($urandom_range(0, 7))
      0: x[30:23] = 8'hFF;
      1: begin x[30:23] = 8'hFF; x[22:0] = 23'h0; end
      2: x[30:23] = 8'h00;
      default: ;
    endcase
    return x;
  endfunction

  int cnt_before;

  initial begin
    tbl[0] = '{1, 0, 32'h3F80_0000, 1, 1, 1, 32'h3F80_0000, 4'b0001, 3'b000};
    tbl[1] = '{1, 0, 32'h7F80_0000, 2, 1, 1, 32'h3F80_0000, 4'b0001, 3'b010};
    tbl[2] = '{1, 0, 32'h0000_0000, 3, 1, 1, 32'h3F80_0000, 4'b0001, 3'b011};
    tbl[3] = '{1, 0, 32'hFFC0_0000, 4, 0, 1, 32'h3F80_0000, 4'b0001, 3'b111};
    tbl[4] = '{0, 1, 32'h0,         3, 1, 1, 32'h7F80_0000, 4'b0100, 3'b111};
    tbl[5] = '{0, 1, 32'h0,         2, 1, 1, 32'h0000_0000, 4'b0010, 3'b111};
    tbl[6] = '{0, 1, 32'h0,         1, 1, 1, NAN_EXP,       4'b1000, 3'b111};
    tbl[7] = '{0, 1, 32'h0,         0, 1, 0, 32'h0,         4'b0000, 3'b111};

    // Reset with traffic asserted: inputs must be ignored.
    cycle(1, 1, 0, 32'h4000_0000, 1);
    cycle(1, 1, 0, 32'h4000_0000, 1);

    // Single normal product, one-cycle latency, then pop.
    cycle(1, 1, 0, 32'h40C0_0000, 0);
    check("a_result", out_result, 32'h40C0_0000);
    check("a_class",  32'(out_class), 32'h1);
    check("a_count",  32'(prod_count), 32'd1);
    check("a_level",  32'(level), 32'd1);
    cycle(0, 1, 0, 32'h0, 0);
    check("a_level_after_pop", 32'(level), 32'd0);

    // Fill to full with one of each class, then drain in order.
    for (int i = 0; i < 8; i++) begin
      cycle(tbl[i].iv, tbl[i].ordy, 0, tbl[i].din, 0);
      check("tbl_level",     32'(level),     32'(tbl[i].e_level));
      check("tbl_in_ready",  32'(in_ready),  32'(tbl[i].e_in_ready));
      check("tbl_out_valid", 32'(out_valid), 32'(tbl[i].e_out_valid));
      check("tbl_result",    out_result,     tbl[i].e_result);
      check("tbl_class",     32'(out_class), 32'(tbl[i].e_class));
      check("tbl_flags",     32'({flag_nan, flag_inf, flag_zero}), 32'(tbl[i].e_flags));
    end

    // Counter saturation.
    cycle(0, 0, 0, 32'h0, 1);
    for (int i = 0; i < 20; i++) cycle(1, 1, 0, rand_fp(), 0);
    check("sat_count", 32'(prod_count), 32'((1 << CW) - 1));

    // Full FIFO with push and pop offered together: pop only.
    cycle(0, 0, 0, 32'h0, 1);
    for (int i = 0; i < DEPTH; i++) cycle(1, 0, 0, 32'h3F80_0000 + 32'(i), 0);
    check("full_level", 32'(level), 32'(DEPTH));
    cycle(1, 1, 0, 32'h4100_0000, 0);
    check("full_popped_level", 32'(level), 32'(DEPTH - 1));
    check("full_in_ready", 32'(in_ready), 32'd1);
    cycle(1, 0, 0, 32'h4100_0000, 0);
    check("fifth_push_level", 32'(level), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) cycle(0, 1, 0, 32'h0, 0);

    // Steady-state streaming at level 2.
    cycle(0, 0, 0, 32'h0, 1);
    cycle(1, 0, 0, 32'h3F00_0000, 0);
    cycle(1, 0, 0, 32'h3F00_0001, 0);
    cnt_before = int'(prod_count);
    for (int i = 0; i < 10; i++) begin
      cycle(1, 1, 0, 32'h4000_0000 + 32'(i), 0);
      check("stream_level", 32'(level), 32'd2);
    end
    check("stream_count_delta", 32'(int'(prod_count) - cnt_before), 32'd10);

    // Sticky clear colliding with a setting push.
    cycle(0, 0, 0, 32'h0, 1);
    cycle(1, 0, 0, 32'h7FC0_0001, 0);
    check("nan_set", 32'(flag_nan), 32'd1);
    cycle(1, 0, 1, 32'h7F80_0001, 0);
    check("nan_set_wins", 32'(flag_nan), 32'd1);
    cycle(0, 0, 1, 32'h0, 0);
    check("nan_cleared", 32'(flag_nan), 32'd0);

    // Negative quiet NaN storage and negative zero sign preservation.
    cycle(0, 0, 0, 32'h0, 1);
    cycle(1, 0, 0, 32'hFFC0_0000, 0);
    check("nan_store", out_result, NAN_EXP);
    check("nan_class", 32'(out_class), 32'h8);
    cycle(1, 1, 0, 32'h8000_0000, 0);
    check("negzero_store", out_result, 32'h8000_0000);

    // Reset while partially full.
    cycle(0, 0, 0, 32'h0, 1);
    cycle(1, 0, 0, 32'h7F80_0000, 0);
    cycle(1, 0, 0, 32'h0000_0000, 0);
    cycle(1, 0, 0, 32'h7FFF_FFFF, 0);
    check("pre_rst_level", 32'(level), 32'd3);
    cycle(1, 1, 0, 32'h4000_0000, 1);
    check("rst_level", 32'(level), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_flags", 32'({flag_nan, flag_inf, flag_zero}), 32'd0);

    // Randomized traffic against the queue model.
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0,
            rand_fp(), $urandom_range(0, 63) == 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
